// File: rtl/decode_stage_pkg.sv
// Shared decode constants: RV opcodes, ALU_OP encodings, out_ctrl bit layout
// and the opcode-to-format classifier used by decode_stage.
package decode_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

   localparam int unsigned CTRL_REG_WRITE  = 7;
   localparam int unsigned CTRL_ALU_SRC    = 6;
   localparam int unsigned CTRL_MEM_WRITE  = 5;
   localparam int unsigned CTRL_ALU_OP_HI  = 4;
   localparam int unsigned CTRL_ALU_OP_LO  = 3;
   localparam int unsigned CTRL_MEM_TO_REG = 2;
   localparam int unsigned CTRL_MEM_READ   = 1;
   localparam int unsigned CTRL_BRANCH     = 0;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
   } fmt_e;

   function automatic fmt_e fmt_of(input logic [6:0] opc);
      case (opc)
         OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt_of = FMT_I;
         OPC_STORE:                     fmt_of = FMT_S;
         OPC_BRANCH:                    fmt_of = FMT_B;
         OPC_LUI, OPC_AUIPC:            fmt_of = FMT_U;
         OPC_JAL:                       fmt_of = FMT_J;
         OPC_OP:                        fmt_of = FMT_R;
         default:                       fmt_of = FMT_BAD;
      endcase
   endfunction

   function automatic logic [7:0] make_ctrl(input logic       reg_write,
                                            input logic       alu_src,
                                            input logic       mem_write,
                                            input logic [1:0] alu_op,
                                            input logic       mem_to_reg,
                                            input logic       mem_read,
                                            input logic       branch);
      logic [7:0] c;
      c                                = '0;
      c[CTRL_REG_WRITE]                = reg_write;
      c[CTRL_ALU_SRC]                  = alu_src;
      c[CTRL_MEM_WRITE]                = mem_write;
      c[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = alu_op;
      c[CTRL_MEM_TO_REG]               = mem_to_reg;
      c[CTRL_MEM_READ]                 = mem_read;
      c[CTRL_BRANCH]                   = branch;
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// NREG x XLEN register file, x0 hard-wired to zero, two read ports that
// forward the same-cycle write-back value.
module regfile_bypass #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            wb_en_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0] regs_q [NREG];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wb_en_i && wb_rd_i != '0 && int'(wb_rd_i) < NREG) begin
         regs_q[wb_rd_i[AW-1:0]] <= wb_data_i;
      end
   end

   // Indices beyond NREG read as zero; the bypass still applies to them.
   always_comb begin
      rs1_data_o = '0;
      rs2_data_o = '0;
      if (rs1_i != '0) begin
         if (wb_en_i && wb_rd_i == rs1_i)  rs1_data_o = wb_data_i;
         else if (int'(rs1_i) < NREG)      rs1_data_o = regs_q[rs1_i[AW-1:0]];
      end
      if (rs2_i != '0) begin
         if (wb_en_i && wb_rd_i == rs2_i)  rs2_data_o = wb_data_i;
         else if (int'(rs2_i) < NREG)      rs2_data_o = regs_q[rs2_i[AW-1:0]];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode pipeline stage: combinational immediate/control decode,
// load-use hazard stall, registered output bundle with valid/ready handshake.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic            flush,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [4:0]      out_rd,
   output logic [3:0]      out_func,
   output logic [7:0]      out_ctrl,
   output logic            out_illegal
);

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2;
   fmt_e            fmt;
   logic [31:0]     imm32;
   logic [7:0]      ctrl;
   logic            illegal, uses_rs1, uses_rs2;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            hazard, accept;

   assign opcode = in_instr[6:0];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign fmt    = fmt_of(opcode);

   always_comb begin
      imm32    = '0;
      ctrl     = '0;
      illegal  = 1'b0;
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      case (fmt)
         FMT_I: begin
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            if (opcode == OPC_LOAD)
               ctrl = make_ctrl(1'b1, 1'b1, 1'b0, ALU_OP_ADD, 1'b1, 1'b1, 1'b0);
            else if (opcode == OPC_OPIMM)
               ctrl = make_ctrl(1'b1, 1'b1, 1'b0, ALU_OP_ITYPE, 1'b0, 1'b0, 1'b0);
            else
               ctrl = make_ctrl(1'b1, 1'b1, 1'b0, ALU_OP_ADD, 1'b0, 1'b0, 1'b0);
         end
         FMT_S: begin
            imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            ctrl     = make_ctrl(1'b0, 1'b1, 1'b1, ALU_OP_ADD, 1'b0, 1'b0, 1'b0);
            uses_rs2 = 1'b1;
         end
         FMT_B: begin
            imm32    = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            ctrl     = make_ctrl(1'b0, 1'b0, 1'b0, ALU_OP_BRANCH, 1'b0, 1'b0, 1'b1);
            uses_rs2 = 1'b1;
         end
         FMT_U: begin
            imm32    = {in_instr[31:12], 12'b0};
            ctrl     = make_ctrl(1'b1, 1'b1, 1'b0, ALU_OP_ADD, 1'b0, 1'b0, 1'b0);
            uses_rs1 = 1'b0;
         end
         FMT_J: begin
            imm32    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            ctrl     = make_ctrl(1'b1, 1'b1, 1'b0, ALU_OP_ADD, 1'b0, 1'b0, 1'b0);
            uses_rs1 = 1'b0;
         end
         FMT_R: begin
            ctrl     = make_ctrl(1'b1, 1'b0, 1'b0, ALU_OP_RTYPE, 1'b0, 1'b0, 1'b0);
            uses_rs2 = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk_i      (clk),
      .reset_i    (reset),
      .wb_en_i    (wb_en),
      .wb_rd_i    (wb_rd),
      .wb_data_i  (wb_data),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data)
   );

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [3:0]      func_q, func_d;
   logic [7:0]      ctrl_q, ctrl_d;
   logic            illegal_q, illegal_d;

   assign hazard   = in_valid && ex_mem_read && ex_rd != '0 &&
                     ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
   assign in_ready = !reset && (!valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      func_d     = func_q;
      ctrl_d     = ctrl_q;
      illegal_d  = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         imm_d      = XLEN'(signed'(imm32));
         rs1_data_d = rs1_data;
         rs2_data_d = rs2_data;
         rd_d       = in_instr[11:7];
         rs1_d      = rs1;
         rs2_d      = rs2;
         func_d     = {in_instr[30], in_instr[14:12]};
         ctrl_d     = ctrl;
         illegal_d  = illegal;
      end else if (valid_q && !out_ready) begin
         // Held operands keep tracking write-backs so EX never sees stale data.
         if (wb_en && wb_rd != '0 && wb_rd == rs1_q) rs1_data_d = wb_data;
         if (wb_en && wb_rd != '0 && wb_rd == rs2_q) rs2_data_d = wb_data;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         func_q     <= '0;
         ctrl_q     <= '0;
         illegal_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         func_q     <= func_d;
         ctrl_q     <= ctrl_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_imm      = imm_q;
   assign out_rs1_data = rs1_data_q;
   assign out_rs2_data = rs2_data_q;
   assign out_rd       = rd_q;
   assign out_func     = func_q;
   assign out_ctrl     = ctrl_q;
   assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage (XLEN=64 and XLEN=32 instances in lockstep)
// against a behavioural model, plus directed scenarios.
module tb_decode_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, flush, ex_mem_read, wb_en, out_ready;
   logic [63:0] in_pc, wb_data;
   logic [31:0] in_instr;
   logic [4:0]  ex_rd, wb_rd;

   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_pc, out_imm, out_rs1_data, out_rs2_data;
   logic [4:0]  out_rd;
   logic [3:0]  out_func;
   logic [7:0]  out_ctrl;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_pc32, out_imm32, out_rs1_data32, out_rs2_data32;
   logic [4:0]  out_rd32;
   logic [3:0]  out_func32;
   logic [7:0]  out_ctrl32;

   decode_stage #(.XLEN(64), .NREG(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_func(out_func), .out_ctrl(out_ctrl),
      .out_illegal(out_illegal)
   );

   decode_stage #(.XLEN(32), .NREG(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
      .in_pc(in_pc[31:0]), .in_instr(in_instr), .flush(flush),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready),
      .out_pc(out_pc32), .out_imm(out_imm32),
      .out_rs1_data(out_rs1_data32), .out_rs2_data(out_rs2_data32),
      .out_rd(out_rd32), .out_func(out_func32), .out_ctrl(out_ctrl32),
      .out_illegal(out_illegal32)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural model: architectural registers plus the one-deep output slot.
   logic [63:0] m_rf [32];
   logic        m_valid;
   logic [63:0] m_pc, m_imm, m_a, m_b;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic [3:0]  m_func;
   logic [7:0]  m_ctrl;
   logic        m_ill;

   task automatic ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                             output logic [7:0] ctrl, output logic ill,
                             output logic u1, output logic u2);
      longint v;
      v = 0; ctrl = 8'b0000_0000; ill = 1'b0; u1 = 1'b1; u2 = 1'b0;
      case (ins[6:0])
         7'b0000011: begin v = $signed(ins[31:20]); ctrl = 8'b1100_0110; end
         7'b0010011: begin v = $signed(ins[31:20]); ctrl = 8'b1101_1000; end
         7'b1100111: begin v = $signed(ins[31:20]); ctrl = 8'b1100_0000; end
         7'b0100011: begin v = $signed({ins[31:25], ins[11:7]}); ctrl = 8'b0110_0000; u2 = 1'b1; end
         7'b1100011: begin
            v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            ctrl = 8'b0000_1001; u2 = 1'b1;
         end
         7'b0110111, 7'b0010111: begin
            v = $signed({ins[31:12], 12'b0}); ctrl = 8'b1100_0000; u1 = 1'b0;
         end
         7'b1101111: begin
            v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            ctrl = 8'b1100_0000; u1 = 1'b0;
         end
         7'b0110011: begin ctrl = 8'b1001_0000; u2 = 1'b1; end
         default: ill = 1'b1;
      endcase
      imm = 64'(v);
   endtask

   function automatic logic [63:0] rf_read(input logic [4:0] idx);
      if (idx == 0) return 64'h0;
      if (wb_en && wb_rd == idx) return wb_data;
      return m_rf[idx];
   endfunction

   task automatic idle();
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic step();
      logic [63:0] imm;
      logic [7:0]  ctrl;
      logic        ill, u1, u2, hazard, rdy;
      logic [4:0]  rs1, rs2;
      @(negedge clk);
      ref_decode(in_instr, imm, ctrl, ill, u1, u2);
      rs1 = in_instr[19:15];
      rs2 = in_instr[24:20];
      hazard = in_valid && ex_mem_read && ex_rd != 0 &&
               ((u1 && ex_rd == rs1) || (u2 && ex_rd == rs2));
      rdy = !reset && (!m_valid || out_ready) && !hazard && !flush;
      chk("in_ready", {63'b0, in_ready}, {63'b0, rdy});
      chk("in_ready32", {63'b0, in_ready32}, {63'b0, rdy});
      if (reset) begin
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
         m_valid = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0;
         m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_func = 0; m_ctrl = 0; m_ill = 0;
      end else begin
         if (flush) m_valid = 0;
         else if (in_valid && rdy) begin
            m_valid = 1; m_pc = in_pc; m_imm = imm; m_a = rf_read(rs1); m_b = rf_read(rs2);
            m_rd = in_instr[11:7]; m_rs1 = rs1; m_rs2 = rs2;
            m_func = {in_instr[30], in_instr[14:12]}; m_ctrl = ctrl; m_ill = ill;
         end else if (m_valid && !out_ready) begin
            if (wb_en && wb_rd != 0 && wb_rd == m_rs1) m_a = wb_data;
            if (wb_en && wb_rd != 0 && wb_rd == m_rs2) m_b = wb_data;
         end else m_valid = 0;
         if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
      chk("out_valid32", {63'b0, out_valid32}, {63'b0, m_valid});
      if (m_valid || reset) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_imm", out_imm, m_imm);
         chk("out_rs1", out_rs1_data, m_a);
         chk("out_rs2", out_rs2_data, m_b);
         chk("out_rd", {59'b0, out_rd}, {59'b0, m_rd});
         chk("out_func", {60'b0, out_func}, {60'b0, m_func});
         chk("out_ctrl", {56'b0, out_ctrl}, {56'b0, m_ctrl});
         chk("out_illegal", {63'b0, out_illegal}, {63'b0, m_ill});
         chk("out_pc32", {32'b0, out_pc32}, {32'b0, m_pc[31:0]});
         chk("out_imm32", {32'b0, out_imm32}, {32'b0, m_imm[31:0]});
         chk("out_rs1_32", {32'b0, out_rs1_data32}, {32'b0, m_a[31:0]});
         chk("out_rs2_32", {32'b0, out_rs2_data32}, {32'b0, m_b[31:0]});
         chk("out_ctrl32", {56'b0, out_ctrl32}, {56'b0, m_ctrl});
      end
   endtask

   logic [6:0] opcs [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                             7'b0111011, 7'b1111111};

   initial begin
      m_valid = 0;
      idle();
      in_pc = '0; in_instr = '0;

      // Reset with a pending offer: nothing accepted, everything zero.
      reset = 1'b1; in_valid = 1'b1; in_instr = 32'h005280B3;
      step();
      step();
      idle();

      // Load x5 then add x1,x5,x5
      wb_en = 1; wb_rd = 5; wb_data = 64'h1234;
      step();
      idle(); in_valid = 1; in_pc = 64'h100; in_instr = 32'h005280B3;
      step();
      chk("add_valid", {63'b0, out_valid}, 64'h1);
      chk("add_rs1", out_rs1_data, 64'h1234);
      chk("add_rs2", out_rs2_data, 64'h1234);
      chk("add_ctrl", {56'b0, out_ctrl}, 64'h90);

      // sd x6,8(x2) with same-cycle write-back of x6
      idle(); in_valid = 1; in_pc = 64'h104; in_instr = 32'h00613423;
      wb_en = 1; wb_rd = 6; wb_data = 64'hAA;
      step();
      chk("sd_rs2", out_rs2_data, 64'hAA);
      chk("sd_imm", out_imm, 64'h8);
      chk("sd_ctrl", {56'b0, out_ctrl}, 64'h60);

      // Load-use hazard on x7, then released
      idle(); in_valid = 1; in_pc = 64'h108; in_instr = 32'h000380B3;
      ex_mem_read = 1; ex_rd = 7;
      @(negedge clk);
      chk("hazard_ready", {63'b0, in_ready}, 64'h0);
      step();
      chk("hazard_bubble", {63'b0, out_valid}, 64'h0);
      ex_mem_read = 0;
      step();
      chk("hazard_release", {63'b0, out_valid}, 64'h1);

      // Hold with rs1=x9, write-back x9 while stalled
      idle(); in_valid = 1; in_pc = 64'h10C; in_instr = 32'h000481B3;
      step();
      idle(); out_ready = 0; wb_en = 1; wb_rd = 9; wb_data = 64'h55;
      step();
      chk("hold_rs1", out_rs1_data, 64'h55);
      chk("hold_pc", out_pc, 64'h10C);
      idle(); out_ready = 0;
      step();

      // beq with imm=-4, then flush while valid
      idle(); in_valid = 1; in_pc = 64'h110; in_instr = 32'hFE208EE3;
      step();
      chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_imm32", {32'b0, out_imm32}, 64'hFFFF_FFFC);
      chk("beq_ctrl", {56'b0, out_ctrl}, 64'h09);
      idle(); out_ready = 0; flush = 1; in_valid = 1;
      step();
      chk("flush_valid", {63'b0, out_valid}, 64'h0);

      // Reset while holding a bundle, with a write-back that must be dropped
      idle(); in_valid = 1; in_instr = 32'h005280B3;
      step();
      idle(); out_ready = 0; reset = 1; wb_en = 1; wb_rd = 5; wb_data = 64'hDEAD;
      step();
      idle(); in_valid = 1; in_instr = 32'h005280B3;
      step();
      chk("reset_wb_dropped", out_rs1_data, 64'h0);

      for (int n = 0; n < 600; n++) begin
         logic [31:0] ins;
         idle();
         reset       = ($urandom_range(0, 99) == 0);
         flush       = ($urandom_range(0, 11) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_rd       = 5'($urandom_range(0, 7));
         wb_en       = ($urandom_range(0, 1) == 1);
         wb_rd       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
         wb_data     = {$urandom, $urandom};
         in_pc       = {$urandom, $urandom};
         ins         = $urandom;
         ins[6:0]    = opcs[$urandom_range(0, 10)];
         ins[19:15]  = 5'($urandom_range(0, 7));
         ins[24:20]  = 5'($urandom_range(0, 7));
         in_instr    = ins;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/register width (32 or 64).
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count (power of 2, max 32).
REQ-003 SHALL have a single clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  fetch offers in_pc/in_instr.
REQ-007 in_ready  out  1  stage accepts this cycle.
REQ-008 in_pc  in  XLEN  PC of offered instruction.
REQ-009 in_instr  in  32  offered instruction.
REQ-010 flush  in  1  kill held/incoming instruction.
REQ-011 ex_mem_read  in  1  instruction in EX is a load.
REQ-012 ex_rd  in  5  destination of EX instruction.
REQ-013 wb_en  in  1  write-back enable.
REQ-014 wb_rd  in  5  write-back register index.
REQ-015 wb_data  in  XLEN  write-back data.
REQ-016 out_valid  out  1  decoded bundle valid.
REQ-017 out_ready  in  1  EX accepts bundle.
REQ-018 out_pc, out_imm, out_rs1_data, out_rs2_data  out  XLEN each  decoded PC, sign-extended immediate, operands.
REQ-019 out_rd  out  5  destination index; out_func  out  4  {instr[30], instr[14:12]}.
REQ-020 out_ctrl  out  8  {reg_write, alu_src, mem_write, alu_op[1:0], mem_to_reg, mem_read, branch}.
REQ-021 out_illegal  out  1  opcode not in decode table.

Function
REQ-022 Register file: NREG x XLEN; x0 reads 0; write on clk edge when wb_en && wb_rd!=0; wb_rd>=NREG ignored.
REQ-023 Operand read SHALL bypass write-back: wb_en && wb_rd==rs && rs!=0 returns wb_data same cycle.
REQ-024 Immediate by opcode, sign-extended from instr[31] to XLEN: I (0000011, 0010011, 1100111) instr[31:20]; S (0100011) {[31:25],[11:7]}; B (1100011) {[31],[7],[30:25],[11:8],0}; U (0110111, 0010111) {[31:12],12'b0}; J (1101111) {[31],[19:12],[20],[30:21],0}; else 0.
REQ-025 out_ctrl: load 1_1_0_00_1_1_0; store 0_1_1_00_0_0_0; R-type 1_0_0_10_0_0_0; I-ALU 1_1_0_11_0_0_0; branch 0_0_0_01_0_0_1; U/J/jalr reg_write=1, alu_src=1, alu_op 00; unknown: all 0, out_illegal=1.
REQ-026 hazard = in_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)); uses_rs1 false for U/J; uses_rs2 true only for R/S/B.
REQ-027 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-028 Accept (in_valid && in_ready): output bundle registered next edge, out_valid=1; latency 1 cycle.
REQ-029 hazard with slot free: bubble, out_valid=0 next cycle; instruction held upstream.
REQ-030 out_valid && !out_ready: all outputs stable, except out_rs1/2_data updated with wb_data if wb_en targets held rs (x0 excluded).
REQ-031 out_valid && out_ready && no accept: out_valid=0 next cycle.
REQ-032 flush SHALL override all: out_valid=0 next cycle, nothing accepted that cycle.

Reset
REQ-033 reset SHALL clear all registers to 0: out_valid=0, all out_* = 0, register file zeroed; in_ready=0 during reset.
REQ-034 reset mid-hold SHALL discard held bundle; no write-back that cycle.

Structure
REQ-035 Package decode_pkg SHALL hold opcode constants, ALU_OP encodings, out_ctrl bit positions.
REQ-036 Sub-module regfile_bypass (parametrised XLEN, NREG) SHALL implement REQ-022/023; immediate/control decode combinational in decode_stage.

Verification
REQ-037 Write x5=0x1234 via wb, then accept add x1,x5,x5 (0x005280B3) -> next cycle out_valid=1, rs1/rs2=0x1234, out_ctrl=8'b1001_0000.
REQ-038 Same-cycle wb x6=0xAA with accept sd x6,8(x2) -> out_rs2_data=0xAA, out_imm=8, out_ctrl=8'b0110_0000.
REQ-039 ex_mem_read=1, ex_rd=7, offered add x1,x7,x0 -> in_ready=0, out_valid=0 next cycle; drop ex_mem_read -> accepted.
REQ-040 out_ready=0 holding rs1=x9, wb x9=0x55 -> out_rs1_data becomes 0x55, other outputs unchanged.
REQ-041 beq with imm=-4 -> out_imm=all-ones...FFFC (XLEN=32 and 64); flush while out_valid -> out_valid=0 next cycle.
